seg7_scan_mux: RTL

//   Time-multiplexed 8-digit seven-segment driver; sits directly downstream of the spinner

---
 rtl/seg7_scan_mux.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
//   Time-multiplexed driver for an 8-digit seven-segment display. It takes the
//   per-digit segment patterns from the upstream pattern logic and drives the
//   board's active-low anode and cathode pins. It provides:
//     - tear-free frame updates: a shadow register is copied to the display
//       register only when the scan wraps from the last digit back to digit 0
//     - per-digit enables
//     - a blanking interval at the start of every digit slot (anti-ghosting)
//     - 4-bit PWM brightness control
//
// Ports
//   CLK100MHZ   in   1             system clock
//   CPU_RESETN  in   1             synchronous reset, active-low
//   seg_in      in   NUM_DIGITS*8  digit i pattern at [8i+7:8i] = {DP,G..A}, 1 = lit
//   load        in   1             strobe: capture seg_in into the shadow register
//   digit_en    in   NUM_DIGITS    per-digit enable, 0 = digit never lit
//   brightness  in   4             0 = off, 1..14 = n/16 duty, 15 = full on
//   frame_start out  1             one-cycle pulse on the first output cycle of digit 0
//   AN          out  NUM_DIGITS    anode selects, active-low
//   CA..CG, DP  out  1 each        cathodes, active-low
module seg7_scan_mux #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic                      CLK100MHZ,
    input  logic                      CPU_RESETN,
    input  logic [NUM_DIGITS*8-1:0]   seg_in,
    input  logic                      load,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic [3:0]                brightness,
    output logic                      frame_start,
    output logic [NUM_DIGITS-1:0]     AN,
    output logic                      CA,
    output logic                      CB,
    output logic                      CC,
    output logic                      CD,
    output logic                      CE,
    output logic                      CF,
    output logic                      CG,
    output logic                      DP
);

    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // PWM gate: level 15 is always on, level 0 always off, otherwise on for
    // the first 'level' phases of each 16-clock PWM period.
    function automatic logic pwm_on(input logic [3:0] level, input logic [3:0] phase);
        return (level == 4'hF) || ((level != 4'h0) && (phase < level));
    endfunction

    logic [CNT_W-1:0]                 cycle_cnt_p0;
    logic [IDX_W-1:0]                 digit_idx_p0;
    logic [3:0]                       pwm_cnt_p0;
    logic                             wrap_p0;
    logic [NUM_DIGITS-1:0][7:0]       shadow;
    logic [NUM_DIGITS-1:0][7:0]       display_p0;

    logic                             slot_end;
    logic                             frame_end;
    logic                             lit;
    logic [NUM_DIGITS-1:0]            an_next;
    logic [7:0]                       seg_next;

    logic [NUM_DIGITS-1:0]            an_p1;
    logic [7:0]                       seg_p1;
    logic                             frame_start_p1;

    assign slot_end  = (cycle_cnt_p0 == CNT_LAST);
    assign frame_end = slot_end && (digit_idx_p0 == IDX_LAST);

    // ---- Stage p0: scan counters, PWM phase, shadow/display registers ----
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            cycle_cnt_p0 <= '0;
            digit_idx_p0 <= '0;
            pwm_cnt_p0   <= '0;
            wrap_p0      <= 1'b0;
            shadow       <= '0;
            display_p0   <= '0;
        end else begin
            cycle_cnt_p0 <= slot_end ? '0 : cycle_cnt_p0 + CNT_W'(1);
            if (slot_end) begin
                digit_idx_p0 <= (digit_idx_p0 == IDX_LAST) ? '0 : digit_idx_p0 + IDX_W'(1);
            end
            pwm_cnt_p0 <= (pwm_cnt_p0 == 4'hF) ? 4'h0 : pwm_cnt_p0 + 4'h1;
            // Marks the first counter state of a new frame; it is carried into
            // the output stage so frame_start lines up with digit 0 on the pins.
            wrap_p0 <= frame_end;
            if (load) begin
                shadow <= seg_in;
            end
            // A load landing on the wrap edge bypasses the shadow so the new
            // pattern appears in the frame that is just starting.
            if (frame_end) begin
                display_p0 <= load ? seg_in : shadow;
            end
        end
    end

    always_comb begin
        an_next  = '1;
        seg_next = 8'hFF;
        lit      = (cycle_cnt_p0 >= CNT_BLANK) && digit_en[digit_idx_p0] &&
                   pwm_on(brightness, pwm_cnt_p0);
        if (lit) begin
            an_next[digit_idx_p0] = 1'b0;
            seg_next              = ~display_p0[digit_idx_p0];
        end
    end

    // ---- Stage p1: registered pin drivers ----
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            an_p1          <= '1;
            seg_p1         <= 8'hFF;
            frame_start_p1 <= 1'b0;
        end else begin
            an_p1          <= an_next;
            seg_p1         <= seg_next;
            frame_start_p1 <= wrap_p0;
        end
    end

    assign AN          = an_p1;
    assign frame_start = frame_start_p1;
    assign {DP, CG, CF, CE, CD, CC, CB, CA} = seg_p1;

endmodule
